// File: rtl/wishbone_timer_if.sv
// Wishbone pipelined bus bundle shared by the CPU data port and its responders.
// The master drives the request fields; the slave drives the response fields.
interface wishbone_interface;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_mosi;
   logic [31:0] dat_miso;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (
      output cyc, stb, we, adr, sel, dat_mosi,
      input  dat_miso, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_mosi,
      output dat_miso, ack, err, stall
   );
endinterface

// File: rtl/wishbone_timer.sv
// Machine timer responder: 64-bit mtime with prescaler, 64-bit mtimecmp and a
// registered level interrupt while mtime >= mtimecmp.
module wishbone_timer #(
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   wishbone_interface.slave  wb,
   output logic              timer_interrupt_out
);

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_PRESCALE    = 3'd5;

   logic [63:0]               mtime_q, mtime_d;
   logic [63:0]               mtimecmp_q, mtimecmp_d;
   logic                      enable_q, enable_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
   logic                      ack_q, ack_d;
   logic                      err_q, err_d;
   logic [31:0]               rdata_q, rdata_d;
   logic                      irq_q;

   logic        access;
   logic        wr_en;
   logic        mapped;
   logic [2:0]  offset;
   logic        tick;
   logic [63:0] mtime_inc;
   logic [31:0] wr_mask;
   logic [31:0] prescale_wr;
   logic        unused_adr;

   assign access    = wb.cyc & wb.stb;
   assign wr_en     = access & wb.we;
   assign offset    = wb.adr[4:2];
   assign mapped    = ~(offset[2] & offset[1]);
   assign tick      = enable_q & (pcnt_q == prescale_q);
   assign mtime_inc = mtime_q + 64'd1;
   assign unused_adr = &{1'b0, wb.adr[31:5], wb.adr[1:0]};

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign wr_mask[gi*8 +: 8] = {8{wb.sel[gi]}};
   end

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask_v);
      return (old_v & ~mask_v) | (new_v & mask_v);
   endfunction

   assign prescale_wr = lane_merge(32'(prescale_q), wb.dat_mosi, wr_mask);

   // Counting first, then bus writes override; a write to one mtime half
   // leaves the other half with its incremented (carried) value.
   always_comb begin
      mtime_d    = tick ? mtime_inc : mtime_q;
      mtimecmp_d = mtimecmp_q;
      enable_d   = enable_q;
      prescale_d = prescale_q;
      pcnt_d     = pcnt_q;
      if (enable_q) begin
         pcnt_d = tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
      end
      if (wr_en) begin
         case (offset)
            OFF_MTIME_LO:    mtime_d[31:0]     = lane_merge(mtime_d[31:0], wb.dat_mosi, wr_mask);
            OFF_MTIME_HI:    mtime_d[63:32]    = lane_merge(mtime_d[63:32], wb.dat_mosi, wr_mask);
            OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = lane_merge(mtimecmp_q[31:0], wb.dat_mosi, wr_mask);
            OFF_MTIMECMP_HI: mtimecmp_d[63:32] = lane_merge(mtimecmp_q[63:32], wb.dat_mosi, wr_mask);
            OFF_CTRL: begin
               if (wb.sel[0]) enable_d = wb.dat_mosi[0];
            end
            OFF_PRESCALE: begin
               prescale_d = prescale_wr[PRESCALE_WIDTH-1:0];
               pcnt_d     = '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ack_d   = access & mapped;
      err_d   = access & ~mapped;
      rdata_d = '0;
      if (access && !wb.we) begin
         case (offset)
            OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
            OFF_MTIME_HI:    rdata_d = mtime_q[63:32];
            OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
            OFF_CTRL:        rdata_d = {31'd0, enable_q};
            OFF_PRESCALE:    rdata_d = 32'(prescale_q);
            default:         rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         enable_q   <= 1'b1;
         prescale_q <= '0;
         pcnt_q     <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         enable_q   <= enable_d;
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         irq_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   // A master that drops cyc abandons the response still in flight.
   assign wb.ack      = ack_q & wb.cyc;
   assign wb.err      = err_q & wb.cyc;
   assign wb.dat_miso = (ack_q & wb.cyc) ? rdata_q : 32'd0;
   assign wb.stall    = 1'b0;

   assign timer_interrupt_out = irq_q;

endmodule
